// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_t     : arbiter FSM encoding (IDLE / ACC / RESP)
//   ID_CPU/LDR  : requester identifiers used for owner/last/grant_id
//   *_W_DEF     : default data and address widths
package mem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ID_CPU = 1'b0;
    localparam logic ID_LDR = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: combinational two-way picker for the memory arbiter.
//   req_cpu, req_ldr : pending requests
//   lock             : loader lock (loader owns the memory, CPU never wins)
//   last             : previous winner (round-robin history)
//   grant_valid      : some requester wins this arbitration
//   grant_id         : winner (ID_CPU / ID_LDR), meaningful when grant_valid
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req_cpu,
    input  logic req_ldr,
    input  logic lock,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ID_CPU;
        // Loader wins when locked, when alone, or on a tie after a CPU win.
        if (req_ldr && (lock || !req_cpu || last == ID_CPU)) begin
            grant_valid = 1'b1;
            grant_id    = ID_LDR;
        // Under lock the CPU is never granted, even with the loader idle.
        end else if (req_cpu && !lock) begin
            grant_valid = 1'b1;
            grant_id    = ID_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between the CPU and program loader.
//   clk, reset          : clock, async active-low reset
//   cpu_* / ldr_*       : request/ack ports (level req held until one-cycle ack)
//   ldr_lock            : loader wins every arbitration while high
//   mem_addr/wdata/we   : RAM command, driven from latched request in ACC
//   mem_rdata           : RAM read data, one cycle after address
//   cpu_stall           : cpu_req & ~cpu_ack, freezes the control unit
//   busy                : arbiter not in IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    input  logic              ldr_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t              r_state, w_state_nxt;
    logic                r_owner, r_last, r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_cpu_rdata, r_ldr_rdata;
    logic                w_grant_valid, w_grant_id, w_grant, w_done;

    arb_rr2 u_pick (
        .req_cpu     (cpu_req),
        .req_ldr     (ldr_req),
        .lock        (ldr_lock),
        .last        (r_last),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    // Requests are only looked at in IDLE; ACC/RESP ignore req entirely,
    // so a requester dropping req early still gets its latched access done.
    assign w_grant = (r_state == IDLE) && w_grant_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_state_nxt = ACC;
            ACC:     w_state_nxt = r_we ? IDLE : RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner     <= ID_CPU;
            r_last      <= ID_LDR;   // CPU wins the first tie
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_id;
                r_last  <= w_grant_id;
                r_we    <= (w_grant_id == ID_LDR) ? ldr_we    : cpu_we;
                r_addr  <= (w_grant_id == ID_LDR) ? ldr_addr  : cpu_addr;
                r_wdata <= (w_grant_id == ID_LDR) ? ldr_wdata : cpu_wdata;
            end
            if (r_state == RESP) begin
                if (r_owner == ID_CPU) r_cpu_rdata <= mem_rdata;
                else                   r_ldr_rdata <= mem_rdata;
            end
        end
    end

    // All memory/ack outputs decode registered state only; async reset
    // clears r_state, so mem_we and ack fall the instant reset asserts.
    assign w_done    = ((r_state == ACC) && r_we) || (r_state == RESP);
    assign mem_we    = (r_state == ACC) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_ack   = w_done && (r_owner == ID_CPU);
    assign ldr_ack   = w_done && (r_owner == ID_LDR);
    assign busy      = (r_state != IDLE);
    assign cpu_stall = cpu_req && !cpu_ack;

    // RAM data shows through during the ack cycle, then the captured copy holds.
    assign cpu_rdata = ((r_state == RESP) && (r_owner == ID_CPU)) ? mem_rdata : r_cpu_rdata;
    assign ldr_rdata = ((r_state == RESP) && (r_owner == ID_LDR)) ? mem_rdata : r_ldr_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk, reset;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ldr_req, ldr_we, ldr_ack, ldr_lock;
    logic [9:0]  ldr_addr;
    logic [31:0] ldr_wdata, ldr_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we, busy;

    logic        t_cpu, t_ldr, t_lock, t_last, t_gv, t_gid;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] ram [1024];

    mem_arbiter #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_lock(ldr_lock),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    arb_rr2 u_rr (
        .req_cpu(t_cpu), .req_ldr(t_ldr), .lock(t_lock), .last(t_last),
        .grant_valid(t_gv), .grant_id(t_gid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, read-before-write.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        cpu_req = 0; ldr_req = 0; ldr_lock = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_cpu_ack(input string tag, input int max);
        bit got = 0;
        for (int k = 0; k < max && !got; k++) begin
            @(negedge clk);
            got = cpu_ack;
        end
        chk(tag, got, 1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[5] = 32'h0000_00AB;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
        t_cpu = 0; t_ldr = 0; t_lock = 0; t_last = 0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_acks", {cpu_ack, ldr_ack}, 0);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        // CPU read of RAM[5]
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
        @(negedge clk);
        chk("rd_c1_addr", mem_addr, 10'h005);
        chk("rd_c1_we", mem_we, 0);
        chk("rd_c1_ack", cpu_ack, 0);
        chk("rd_c1_stall", cpu_stall, 1);
        chk("rd_c1_busy", busy, 1);
        @(negedge clk);
        chk("rd_c2_ack", cpu_ack, 1);
        chk("rd_c2_rdata", cpu_rdata, 32'h0000_00AB);
        chk("rd_c2_stall", cpu_stall, 0);
        cpu_req = 0;
        @(negedge clk);
        chk("rd_c3_busy", busy, 0);
        chk("rd_c3_ack", cpu_ack, 0);
        chk("rd_c3_hold", cpu_rdata, 32'h0000_00AB);

        // Loader write 0x3FF
        ldr_req = 1; ldr_we = 1; ldr_addr = 10'h3FF; ldr_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 10'h3FF);
        chk("wr_data", mem_wdata, 32'hDEAD_BEEF);
        chk("wr_ldr_ack", ldr_ack, 1);
        chk("wr_cpu_ack", cpu_ack, 0);
        ldr_req = 0;
        @(negedge clk);
        chk("wr_we_off", mem_we, 0);
        chk("wr_ack_off", ldr_ack, 0);
        chk("wr_ldr_rdata", ldr_rdata, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
        wait_cpu_ack("rb_ack", 10);
        chk("rb_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_req = 0;

        // Both reading, round-robin from reset: C at 2,8; L at 5,11
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
        ldr_req = 1; ldr_we = 0; ldr_addr = 10'h3FF;
        for (int k = 1; k <= 12; k++) begin
            bit ec, el;
            @(negedge clk);
            ec = (k % 6 == 2);
            el = (k % 6 == 5);
            chk($sformatf("rr_cack%0d", k), cpu_ack, ec);
            chk($sformatf("rr_lack%0d", k), ldr_ack, el);
            chk($sformatf("rr_stall%0d", k), cpu_stall, !ec);
            if (ec) chk($sformatf("rr_crd%0d", k), cpu_rdata, 32'h0000_00AB);
            if (el) chk($sformatf("rr_lrd%0d", k), ldr_rdata, 32'hDEAD_BEEF);
        end
        cpu_req = 0; ldr_req = 0;

        // Loader lock: 4 writes, CPU starved, then lock dropped
        do_reset();
        ldr_lock = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h012;
        ldr_req = 1; ldr_we = 1; ldr_addr = 10'h010; ldr_wdata = 32'h100;
        begin
            int i = 0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                chk($sformatf("lk_lack%0d", k), ldr_ack, k % 2);
                chk($sformatf("lk_cack%0d", k), cpu_ack, 0);
                chk($sformatf("lk_stall%0d", k), cpu_stall, 1);
                if (k % 2 == 1) begin
                    chk($sformatf("lk_addr%0d", k), mem_addr, 10'h010 + i);
                    chk($sformatf("lk_data%0d", k), mem_wdata, 32'h100 + i);
                    i++;
                    if (i < 4) begin
                        ldr_addr = 10'h010 + 10'(i);
                        ldr_wdata = 32'h100 + i;
                    end else ldr_lock = 0;
                end
            end
            chk("lk_writes", i, 4);
        end
        @(negedge clk);
        chk("ul_addr", mem_addr, 10'h012);
        chk("ul_we", mem_we, 0);
        @(negedge clk);
        chk("ul_cack", cpu_ack, 1);
        chk("ul_lack", ldr_ack, 0);
        chk("ul_rdata", cpu_rdata, 32'h102);
        cpu_req = 0; ldr_req = 0;

        // Reset during ACC of a CPU write
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h020; cpu_wdata = 32'h55;
        @(posedge clk);
        #1;
        chk("ra_pre_we", mem_we, 1);
        #1 reset = 1'b0;
        #1;
        chk("ra_we", mem_we, 0);
        chk("ra_ack", cpu_ack, 0);
        chk("ra_busy", busy, 0);
        chk("ra_addr", mem_addr, 0);
        chk("ra_wdata", mem_wdata, 0);
        chk("ra_rdata", {cpu_rdata, ldr_rdata}, 0);
        @(negedge clk);
        chk("ra_ram", ram[10'h020], 0);
        reset = 1'b1;
        wait_cpu_ack("ra_redo_ack", 10);
        chk("ra_redo_we", mem_we, 1);
        chk("ra_redo_addr", mem_addr, 10'h020);
        cpu_req = 0;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h020;
        wait_cpu_ack("ra_rb_ack", 10);
        chk("ra_rb_rdata", cpu_rdata, 32'h55);
        cpu_req = 0;

        // arb_rr2 exhaustive
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vb;
            logic ev, eid;
            vb = 4'(v);
            {t_cpu, t_ldr, t_lock, t_last} = vb;
            #1;
            ev  = t_lock ? t_ldr : (t_cpu | t_ldr);
            eid = t_lock ? ID_LDR : ((t_cpu & t_ldr) ? ~t_last : t_ldr);
            chk($sformatf("rr2_%0d", v), {t_gv, t_gv & t_gid}, {ev, ev & eid});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the processor's single synchronous memory between the control unit's fetch/load/store path (CPU port) and the external program loader (LDR port). It sits between the requesters and the memory. It grants one access at a time, round-robin or loader-locked, and raises a stall so the control unit FSM holds its state while the memory is busy.

## Interface
Parameters:
- DATA_W, 32, memory word width
- ADDR_W, 10, memory word-address width

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (level, held until cpu_ack)
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack of a read
- cpu_stall  out  1  cpu_req & ~cpu_ack (freezes control-unit state)
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata  same as CPU set, for loader
- ldr_lock  in  1  while high, loader wins every arbitration and CPU is never granted
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data, one cycle after address (synchronous RAM)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACC, RESP. Registers: state, owner (CPU/LDR), last (last winner), latched we/addr/wdata.
- IDLE: sample requests.
  - None: stay.
  - One: grant it.
  - Both, ldr_lock=1: LDR.
  - Both, ldr_lock=0: the one not equal to last.
  - On grant: latch owner's we/addr/wdata; last <= owner; go to ACC.
- ACC: mem_addr/mem_wdata driven from latches.
  - Write: mem_we=1, owner ack=1, next IDLE.
  - Read: mem_we=0, next RESP.
- RESP: owner rdata = mem_rdata, owner ack=1, next IDLE.
- ack goes only to owner; the other port's ack is 0.
- rdata outputs are registered and hold their last value until the next read ack for that port.
- Requester deasserts req on the edge ending its ack cycle. The arbiter samples req only in IDLE, so no duplicate access occurs.
- ldr_lock rising mid-CPU-access does not abort that access. It takes effect at the next IDLE.
- Req dropping before ack is a protocol violation. The arbiter completes the latched access anyway.
- Reset (async, low) values:
  - state=IDLE, last=LDR (CPU wins first tie), owner=CPU.
  - mem_we=0, both acks 0, both rdata 0, mem_addr/mem_wdata 0, busy=0.
- Reset mid-access aborts immediately. mem_we drops asynchronously, and no ack is issued.

## Timing
- Request sampled high at edge n in IDLE:
  - Write: ACC in cycle n+1 with mem_we and ack; IDLE at n+2.
  - Read: ACC in n+1, RESP/ack in n+2, IDLE at n+3.
- Back-to-back throughput: write 1 per 2 cycles, read 1 per 3 cycles. The IDLE bubble is mandatory.
- mem_we, mem_addr, mem_wdata, ack, busy are registered-state decodes. There is no combinational path from req to mem_* or ack.
- cpu_stall is combinational from cpu_req and cpu_ack.

## Structure
- Package mem_arb_pkg holds: state encoding (IDLE=2'd0, ACC=2'd1, RESP=2'd2), requester ID constants (ID_CPU=1'b0, ID_LDR=1'b1), and default widths.
- One sub-module, arb_rr2: combinational 2-way picker (req_cpu, req_ldr, lock, last -> grant_valid, grant_id). It is kept separate for standalone exhaustive test.

## Test plan
- Reset, then cpu_req read addr 0x005 with RAM[5]=0x0000_00AB:
  - mem_addr=0x005 in cycle 1.
  - cpu_ack with cpu_rdata=0x0000_00AB in cycle 2.
  - busy low in cycle 3.
- ldr_req write addr 0x3FF data 0xDEAD_BEEF:
  - mem_we=1 for exactly one cycle with those values.
  - ldr_ack in the same cycle.
  - Readback via CPU returns 0xDEAD_BEEF.
- Both requesters continuously reading, ldr_lock=0:
  - Grants alternate CPU, LDR, CPU, LDR.
  - CPU is first after reset.
  - cpu_stall high exactly while CPU waits.
- ldr_lock=1 with both requesting: 4 consecutive LDR writes complete, zero CPU acks, cpu_stall held high. Drop lock: the CPU is granted at the next IDLE.
- Reset asserted during the ACC cycle of a CPU write:
  - mem_we drops immediately, no cpu_ack.
  - All outputs at reset values.
  - After release, a re-issued request completes normally.
- arb_rr2 exhaustive: all 16 input combinations match the priority rules above.
